// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package mem_stage_lsu_pkg;

   typedef logic [4:0] RegAddr;

   typedef enum logic [1:0] {IDLE, REQ, RESP} LsuState;

   localparam logic [31:0] DEADBEEF_WORD   = 32'hDEAD_BEEF;
   localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return (low_bits & WORD_ALIGN_MASK) != 2'b00;
   endfunction

endpackage

// File: rtl/mem_stage_lsu_mem_wb_reg.sv
// Memory/writeback pipeline register; inserts a bubble while the memory stage stalls.
module mem_wb_reg
   import mem_stage_lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bubble,
   input  logic              kill,
   input  logic              load_mem,
   input  logic              reg_write,
   input  logic              memToReg,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] mem_word,
   input  RegAddr            rd_a,
   output logic              reg_write_o,
   output logic              memToReg_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic [DATA_W-1:0] alu_out_o,
   output RegAddr            rd_a_o
);

   // A bubble clears the control bits but leaves the data registers holding their last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_o <= 1'b0;
         memToReg_o  <= 1'b0;
         mem_data_o  <= '0;
         alu_out_o   <= '0;
         rd_a_o      <= '0;
      end else begin
         if (bubble) begin
            reg_write_o <= 1'b0;
            memToReg_o  <= 1'b0;
            rd_a_o      <= '0;
         end else begin
            reg_write_o <= reg_write & ~kill;
            memToReg_o  <= memToReg;
            alu_out_o   <= alu_out;
            rd_a_o      <= rd_a;
         end
         if (load_mem)
            mem_data_o <= mem_word;
      end
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: dmem handshake FSM, pipeline stall and MW register.
// Optional watchdog with bus_err_o is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_write,
   input  logic              read_mem,
   input  logic              write_mem,
   input  logic              memToReg,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] write_d,
   input  RegAddr            rd_a,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              stall_o,
   output logic              misalign_o,
`ifdef MEM_TIMEOUT_EN
   output logic              bus_err_o,
`endif
   output logic              reg_write_o,
   output logic              memToReg_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic [DATA_W-1:0] alu_out_o,
   output RegAddr            rd_a_o,
   output logic [DATA_W-1:0] M_d
);

   LsuState           state;
   logic              mem_op;
   logic              is_store;
   logic              misaligned;
   logic              done;
   logic              timeout;
   logic              load_mem;
   logic [DATA_W-1:0] mem_word;

   // A simultaneous read and write request is handled as a load.
   assign mem_op     = read_mem | write_mem;
   assign is_store   = write_mem & ~read_mem;
   assign misaligned = mem_op & is_misaligned(alu_out[1:0]);
   assign done       = (state == REQ && dmem_gnt && is_store) ||
                       (state == RESP && dmem_rvalid) || timeout;
   assign stall_o    = mem_op & ~misaligned & ~done;

   assign dmem_addr  = alu_out;
   assign dmem_wdata = write_d;

   assign load_mem   = (state == RESP && dmem_rvalid) || (timeout && !is_store);
   assign mem_word   = timeout ? DATA_W'(DEADBEEF_WORD) : dmem_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         misalign_o <= 1'b0;
      end else begin
         misalign_o <= misaligned;
         case (state)
            IDLE: begin
               if (mem_op && !misaligned) begin
                  state    <= REQ;
                  dmem_req <= 1'b1;
                  dmem_we  <= is_store;
               end
            end
            REQ: begin
               if (done) begin
                  state    <= IDLE;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
               end else if (dmem_gnt) begin
                  state    <= RESP;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
               end
            end
            RESP: begin
               if (done)
                  state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_TIMEOUT_EN
   logic [7:0] wdog;

   // The watchdog spans REQ and RESP together and restarts with every new op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog      <= '0;
         bus_err_o <= 1'b0;
      end else begin
         bus_err_o <= timeout;
         if (state == IDLE || done)
            wdog <= '0;
         else
            wdog <= wdog + 8'd1;
      end
   end

   assign timeout = (state != IDLE) && (wdog == 8'(TIMEOUT - 1));
`else
   assign timeout = 1'b0;
`endif

   mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb_reg (
      .clk         (clk),
      .rst         (rst),
      .bubble      (stall_o),
      .kill        (misaligned | timeout),
      .load_mem    (load_mem),
      .reg_write   (reg_write),
      .memToReg    (memToReg),
      .alu_out     (alu_out),
      .mem_word    (mem_word),
      .rd_a        (rd_a),
      .reg_write_o (reg_write_o),
      .memToReg_o  (memToReg_o),
      .mem_data_o  (mem_data_o),
      .alu_out_o   (alu_out_o),
      .rd_a_o      (rd_a_o)
   );

   assign M_d = memToReg_o ? mem_data_o : alu_out_o;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: vector table for single-cycle ops plus multi-cycle sequences.
module tb_mem_stage_lsu;
   import mem_stage_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_write, read_mem, write_mem, memToReg;
   logic [31:0] alu_out, write_d;
   RegAddr      rd_a;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        stall_o, misalign_o;
   logic        reg_write_o, memToReg_o;
   logic [31:0] mem_data_o, alu_out_o, M_d;
   RegAddr      rd_a_o;
`ifdef MEM_TIMEOUT_EN
   logic        bus_err_o;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rw, rm, wm, m2r;
      logic [31:0] alu, wd;
      logic [4:0]  rd;
      logic        full;
      logic        exp_rw, exp_m2r;
      logic [31:0] exp_alu;
      logic [4:0]  exp_rd;
      logic [31:0] exp_md;
      logic        exp_mis;
   } Vec;

   Vec vecs[7];

   mem_stage_lsu #(.DATA_W(32), .TIMEOUT(255)) dut (
      .clk         (clk),
      .rst         (rst),
      .reg_write   (reg_write),
      .read_mem    (read_mem),
      .write_mem   (write_mem),
      .memToReg    (memToReg),
      .alu_out     (alu_out),
      .write_d     (write_d),
      .rd_a        (rd_a),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_gnt    (dmem_gnt),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata),
      .stall_o     (stall_o),
      .misalign_o  (misalign_o),
`ifdef MEM_TIMEOUT_EN
      .bus_err_o   (bus_err_o),
`endif
      .reg_write_o (reg_write_o),
      .memToReg_o  (memToReg_o),
      .mem_data_o  (mem_data_o),
      .alu_out_o   (alu_out_o),
      .rd_a_o      (rd_a_o),
      .M_d         (M_d)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] simulation time limit");
   end

   task automatic applyStimulus(input logic rw, input logic rm, input logic wm, input logic m2r,
                                input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
      reg_write = rw;
      read_mem  = rm;
      write_mem = wm;
      memToReg  = m2r;
      alu_out   = alu;
      write_d   = wd;
      rd_a      = rd;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   initial begin
      int stall_cnt;
      int finished;
      int hi;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10,       32'h0,       5'd5,  1'b1, 1'b1, 1'b0, 32'h10,       5'd5,  32'h10,       1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,       5'd31, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFF, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h3,        32'h0,       5'd0,  1'b1, 1'b0, 1'b0, 32'h3,        5'd0,  32'h3,        1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h102,      32'h0,       5'd7,  1'b0, 1'b0, 1'b0, 32'h0,        5'd0,  32'h0,        1'b1};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h201,      32'hAAAA5555,5'd0,  1'b0, 1'b0, 1'b0, 32'h0,        5'd0,  32'h0,        1'b1};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h3,        32'h0,       5'd9,  1'b0, 1'b0, 1'b0, 32'h0,        5'd0,  32'h0,        1'b1};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h44,       32'h0,       5'd12, 1'b1, 1'b1, 1'b0, 32'h44,       5'd12, 32'h44,       1'b0};

      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      checkOutput("rst dmem_req", dmem_req, 0);
      checkOutput("rst dmem_we", dmem_we, 0);
      checkOutput("rst reg_write_o", reg_write_o, 0);
      checkOutput("rst alu_out_o", alu_out_o, 0);
      checkOutput("rst mem_data_o", mem_data_o, 0);
      checkOutput("rst rd_a_o", rd_a_o, 0);
      checkOutput("rst misalign_o", misalign_o, 0);
      checkOutput("rst stall_o", stall_o, 0);
      rst = 1'b0;

      // Single-cycle ops: non-memory and misaligned accesses never stall.
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i].rw, vecs[i].rm, vecs[i].wm, vecs[i].m2r, vecs[i].alu, vecs[i].wd, vecs[i].rd);
         #1;
         checkOutput($sformatf("vec%0d stall_o", i), stall_o, 0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d dmem_req", i), dmem_req, 0);
         checkOutput($sformatf("vec%0d reg_write_o", i), reg_write_o, vecs[i].exp_rw);
         checkOutput($sformatf("vec%0d misalign_o", i), misalign_o, vecs[i].exp_mis);
         if (vecs[i].full) begin
            checkOutput($sformatf("vec%0d memToReg_o", i), memToReg_o, vecs[i].exp_m2r);
            checkOutput($sformatf("vec%0d alu_out_o", i), alu_out_o, vecs[i].exp_alu);
            checkOutput($sformatf("vec%0d rd_a_o", i), rd_a_o, vecs[i].exp_rd);
            checkOutput($sformatf("vec%0d M_d", i), M_d, vecs[i].exp_md);
         end
      end

      // Load at 0x100: grant in first REQ cycle, data the cycle after.
      @(negedge clk);
      applyStimulus(1, 1, 0, 1, 32'h100, 32'h0, 5'd3);
      #1;
      checkOutput("ld c0 stall_o", stall_o, 1);
      @(negedge clk);
      checkOutput("ld c1 dmem_req", dmem_req, 1);
      checkOutput("ld c1 dmem_we", dmem_we, 0);
      checkOutput("ld c1 dmem_addr", dmem_addr, 32'h100);
      checkOutput("ld c1 bubble reg_write_o", reg_write_o, 0);
      dmem_gnt = 1'b1;
      #1;
      checkOutput("ld c1 stall_o", stall_o, 1);
      @(negedge clk);
      dmem_gnt = 1'b0;
      checkOutput("ld c2 dmem_req", dmem_req, 0);
      dmem_rvalid = 1'b1;
      dmem_rdata = 32'hCAFE0001;
      #1;
      checkOutput("ld c2 stall_o", stall_o, 0);
      @(negedge clk);
      dmem_rvalid = 1'b0;
      dmem_rdata = 32'h0;
      checkOutput("ld mem_data_o", mem_data_o, 32'hCAFE0001);
      checkOutput("ld M_d", M_d, 32'hCAFE0001);
      checkOutput("ld rd_a_o", rd_a_o, 3);
      checkOutput("ld reg_write_o", reg_write_o, 1);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);

      // Store at 0x200 with the grant held off for three REQ cycles.
      @(negedge clk);
      applyStimulus(0, 0, 1, 0, 32'h200, 32'h12345678, 5'd0);
      stall_cnt = 0;
      finished = 0;
      for (int c = 0; c < 12 && finished == 0; c++) begin
         if (c > 0) @(negedge clk);
         dmem_gnt = (c == 4);
         #1;
         if (c >= 1 && c <= 4) begin
            checkOutput($sformatf("st c%0d dmem_req", c), dmem_req, 1);
            checkOutput($sformatf("st c%0d dmem_we", c), dmem_we, 1);
            checkOutput($sformatf("st c%0d dmem_addr", c), dmem_addr, 32'h200);
            checkOutput($sformatf("st c%0d dmem_wdata", c), dmem_wdata, 32'h12345678);
         end
         if (stall_o) stall_cnt++;
         else finished = 1;
      end
      checkOutput("st stall cycles", stall_cnt, 4);
      @(posedge clk);
      #1;
      checkOutput("st reg_write_o", reg_write_o, 0);
      checkOutput("st dmem_req after", dmem_req, 0);
      @(negedge clk);
      dmem_gnt = 1'b0;
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);

      // Reset while waiting in RESP, then a stray rvalid must be ignored.
      @(negedge clk);
      applyStimulus(1, 1, 0, 1, 32'h300, 32'h0, 5'd4);
      @(negedge clk);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      #1;
      checkOutput("rsp wait stall_o", stall_o, 1);
      rst = 1'b1;
      #1;
      checkOutput("rsp rst dmem_req", dmem_req, 0);
      checkOutput("rsp rst reg_write_o", reg_write_o, 0);
      checkOutput("rsp rst alu_out_o", alu_out_o, 0);
      checkOutput("rsp rst mem_data_o", mem_data_o, 0);
      checkOutput("rsp rst rd_a_o", rd_a_o, 0);
      checkOutput("rsp rst M_d", M_d, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      dmem_rvalid = 1'b1;
      dmem_rdata = 32'hBAD0BAD0;
      #1;
      checkOutput("late rvalid stall_o", stall_o, 0);
      @(negedge clk);
      dmem_rvalid = 1'b0;
      checkOutput("late rvalid mem_data_o", mem_data_o, 0);
      checkOutput("late rvalid dmem_req", dmem_req, 0);

`ifdef MEM_TIMEOUT_EN
      // Grant never arrives: watchdog ends the op on the 255th REQ cycle.
      @(negedge clk);
      applyStimulus(1, 1, 0, 1, 32'h400, 32'h0, 5'd6);
      finished = 0;
      for (int c = 1; c <= 300 && finished == 0; c++) begin
         @(negedge clk);
         #1;
         if (!stall_o) finished = c;
      end
      checkOutput("to stall drop cycle", finished, 255);
      @(posedge clk);
      #1;
      checkOutput("to bus_err_o", bus_err_o, 1);
      checkOutput("to mem_data_o", mem_data_o, 32'hDEADBEEF);
      checkOutput("to reg_write_o", reg_write_o, 0);
      checkOutput("to dmem_req", dmem_req, 0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      @(posedge clk);
      #1;
      checkOutput("to bus_err_o pulse end", bus_err_o, 0);
`else
      // Grant never arrives: the unit keeps requesting and stalling.
      @(negedge clk);
      applyStimulus(1, 1, 0, 1, 32'h400, 32'h0, 5'd6);
      hi = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         #1;
         if (stall_o && dmem_req) hi++;
      end
      checkOutput("nogrant stall cycles", hi, 300);
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      @(negedge clk);
      rst = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit; consumes the execute/memory pipeline register outputs and drives the data-memory request/response handshake.
- Raises a stall toward the front of the pipe while a memory op is outstanding.
- Owns the memory/writeback pipeline register and produces the writeback/forwarding value (M_d) that feeds store-data forwarding in the execute/memory register.

Parameters:
- DATA_W, 32, data and address width.
- TIMEOUT, 255, max cycles waiting on dmem_gnt or dmem_rvalid (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- reg_write  in  1  from execute/memory register.
- read_mem  in  1  load op.
- write_mem  in  1  store op.
- memToReg  in  1  writeback selects memory data.
- alu_out  in  DATA_W  effective address or ALU result.
- write_d  in  DATA_W  store data.
- rd_a  in  RegAddr (5)  destination register.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  DATA_W  word address (alu_out).
- dmem_wdata  out  DATA_W  write_d.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  DATA_W  read data.
- stall_o  out  1  freeze PC/IF/ID/EX and the execute/memory register.
- misalign_o  out  1  registered one-cycle pulse: misaligned access dropped.
- reg_write_o  out  1  memory/writeback register.
- memToReg_o  out  1  memory/writeback register.
- mem_data_o  out  DATA_W  memory/writeback register.
- alu_out_o  out  DATA_W  memory/writeback register.
- rd_a_o  out  RegAddr  memory/writeback register.
- M_d  out  DATA_W  memToReg_o ? mem_data_o : alu_out_o (combinational).

Behaviour:
- mem_op = read_mem | write_mem. If both are set, the op is treated as a load.
- Misaligned: alu_out[1:0] != 0 with mem_op.
  - No request is issued and no stall is raised.
  - MW captures a bubble.
  - misalign_o pulses 1 cycle.
- FSM states: IDLE, REQ, RESP.
  - IDLE -> REQ when mem_op & aligned.
  - REQ: dmem_req=1 (registered), dmem_we=write_mem, addr/wdata held from inputs, which are frozen by stall.
    - Store with gnt -> IDLE (done).
    - Load with gnt -> RESP.
    - Otherwise stay in REQ.
  - RESP: wait for dmem_rvalid -> IDLE (done).
  - dmem_rvalid outside RESP is ignored.
- done = (REQ & gnt & store) | (RESP & rvalid).
- stall_o = mem_op & aligned & ~done (combinational).
- Minimum latency, with gnt in the first REQ cycle:
  - Store: 1 stall cycle.
  - Load: 2 stall cycles (rvalid in the cycle after gnt).
- MW register, each rising edge:
  - If stall_o: capture a bubble (reg_write_o=0, memToReg_o=0, rd_a_o=0, data regs hold).
  - Else: capture reg_write (forced 0 if misaligned), memToReg, alu_out, rd_a.
  - mem_data_o captures dmem_rdata when RESP & rvalid; otherwise it holds.
- A store never writes a register (reg_write_o follows the input; the decoder already clears it).
- Reset: state IDLE, dmem_req=0, dmem_we=0, all MW outputs 0, misalign_o=0. A reset mid-transaction abandons the op; the memory side is reset by the same rst.
- Back-to-back ops: the next op enters IDLE on the edge after done and issues REQ the following cycle. There are no idle bubbles beyond that.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles in REQ/RESP.
  - On reaching TIMEOUT, force done.
  - A load returns 32'hDEAD_BEEF to MW with reg_write_o=0.
  - bus_err_o (extra output port) pulses 1 cycle.
  - The state returns to IDLE and the counter clears.
- Undefined: no counter and no bus_err_o port; the unit waits indefinitely.

Decomposition:
- Package definitions gains:
  - LsuState enum {IDLE, REQ, RESP}.
  - Constant DEADBEEF_WORD.
  - Alignment-mask constant WORD_ALIGN_MASK = 2'b11.
- RegAddr is reused from the package.
- One natural sub-module: mem_wb_reg, the memory/writeback pipeline register with bubble-insert control.
- The FSM stays in mem_stage_lsu.

Test Plan:
- Non-memory op: reg_write=1, alu_out=0x10, rd_a=5 -> no stall; next cycle reg_write_o=1, alu_out_o=0x10, rd_a_o=5, M_d=0x10.
- Load at 0x100, gnt in the first REQ cycle, rvalid next cycle, rdata=0xCAFE0001 -> stall_o high 2 cycles; then mem_data_o=0xCAFE0001, M_d=0xCAFE0001, rd_a_o as issued.
- Store at 0x200, data 0x12345678, gnt delayed 3 cycles -> dmem_req/we/addr/wdata stable 3 cycles; stall_o high 4 cycles; reg_write_o=0.
- Load at 0x102 -> no dmem_req, no stall, misalign_o pulse, reg_write_o=0.
- Assert rst while in RESP -> dmem_req=0, state IDLE, all MW outputs 0 immediately; a late rvalid is ignored.
- With MEM_TIMEOUT_EN: load where gnt never arrives -> after 255 cycles in REQ, bus_err_o pulses, stall drops, mem_data_o=0xDEADBEEF, reg_write_o=0.
